// File: rtl/fifomult_pkg.sv
// Shared types and defaults for the fifomult UART receive front end.
package fifomult_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;

  typedef logic [7:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef struct packed {
    addr_t      addr;
    logic [7:0] data;
  } rx_packet_t;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_bad(input logic [7:0] d, input logic p);
    return (^d) ^ p;
  endfunction

endpackage

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 2-flop synchroniser, frame FSM, bit timing and parity.
// Frame format: start, 8 data bits LSB-first, even parity, one stop bit.
// Optional macro UART_PACKET_RX_PARITY_CHECK_EN enables the parity check;
// without it the parity bit is sampled for timing only and ignored.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge on the synchronised line
// START  | timing to mid start bit; line high there means false start
// DATA   | sampling 8 data bits, one per bit period
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit; result strobes issued on that cycle
module uart_rx_frame
  import fifomult_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  // Timer is a down-counter; the sample happens on the cycle it reads zero.
  // The edge-detect cycle counts as the first half-bit cycle, hence the -2.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  logic            sync1_q;
  logic            rxd_s_q;
  logic            prev_q;
  rx_state_t       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            stop_tc;
`ifdef UART_PACKET_RX_PARITY_CHECK_EN
  logic            par_q;
  logic            par_bad;
`endif

  // Synchroniser plus one delay stage for falling-edge detection; resets high
  // so a reset release never looks like a start edge by itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxd_s_q <= sync1_q;
      prev_q  <= rxd_s_q;
    end
  end

  // Frame FSM with bit timer, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
`ifdef UART_PACKET_RX_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (prev_q && !rxd_s_q) begin
            state_q <= START;
            cnt_q   <= HALF_LOAD;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (!rxd_s_q) begin
              state_q   <= DATA;
              cnt_q     <= BIT_LOAD;
              bit_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rxd_s_q, shift_q[7:1]};
            cnt_q   <= BIT_LOAD;
            if (bit_cnt_q == 3'd7) begin
              state_q <= PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == '0) begin
`ifdef UART_PACKET_RX_PARITY_CHECK_EN
            par_q   <= rxd_s_q;
`endif
            cnt_q   <= BIT_LOAD;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result strobes on the stop-sample cycle; a low stop bit masks parity.
  always_comb begin
    stop_tc   = (state_q == STOP) && (cnt_q == '0);
    rx_byte   = shift_q;
    frame_err = stop_tc & ~rxd_s_q;
`ifdef UART_PACKET_RX_PARITY_CHECK_EN
    par_bad    = parity_bad(shift_q, par_q);
    parity_err = stop_tc & rxd_s_q & par_bad;
    byte_valid = stop_tc & rxd_s_q & ~par_bad;
`else
    parity_err = 1'b0;
    byte_valid = stop_tc & rxd_s_q;
`endif
  end

endmodule

// File: rtl/uart_packet_rx.sv
// UART packet receiver: pairs good frames into {address, data} packets and
// holds each one in a single-entry valid/ready output register.
// Parity checking inside uart_rx_frame is enabled by the optional macro
// UART_PACKET_RX_PARITY_CHECK_EN.
module uart_packet_rx
  import fifomult_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic [7:0] pkt_addr,
  output logic [7:0] pkt_data,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       fr_parity_err;
  logic       fr_frame_err;
  logic       handshake;

  logic       have_addr_q,  have_addr_d;
  addr_t      addr_hold_q,  addr_hold_d;
  rx_packet_t pkt_q,        pkt_d;
  logic       pkt_valid_q,  pkt_valid_d;
  logic       overflow_q,   overflow_d;
  logic       parity_err_q;
  logic       frame_err_q;

  uart_rx_frame #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_frame (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .parity_err(fr_parity_err),
    .frame_err (fr_frame_err)
  );

  // Pairing and output register next state; a handshake frees the slot in
  // the same cycle so a packet completing then is loaded, not dropped.
  always_comb begin
    handshake   = pkt_valid_q & pkt_ready;
    have_addr_d = have_addr_q;
    addr_hold_d = addr_hold_q;
    pkt_d       = pkt_q;
    pkt_valid_d = pkt_valid_q;
    overflow_d  = 1'b0;

    if (handshake) begin
      pkt_valid_d = 1'b0;
    end

    if (fr_parity_err || fr_frame_err) begin
      have_addr_d = 1'b0;
    end else if (byte_valid) begin
      if (!have_addr_q) begin
        addr_hold_d = rx_byte;
        have_addr_d = 1'b1;
      end else begin
        have_addr_d = 1'b0;
        if (!pkt_valid_q || handshake) begin
          pkt_d.addr  = addr_hold_q;
          pkt_d.data  = rx_byte;
          pkt_valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  // State and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      have_addr_q  <= 1'b0;
      addr_hold_q  <= '0;
      pkt_q        <= '0;
      pkt_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      have_addr_q  <= have_addr_d;
      addr_hold_q  <= addr_hold_d;
      pkt_q        <= pkt_d;
      pkt_valid_q  <= pkt_valid_d;
      overflow_q   <= overflow_d;
      parity_err_q <= fr_parity_err;
      frame_err_q  <= fr_frame_err;
    end
  end

  assign pkt_valid  = pkt_valid_q;
  assign pkt_addr   = pkt_q.addr;
  assign pkt_data   = pkt_q.data;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Scoreboard bench for uart_packet_rx: expected packets are queued as frames
// are sent and compared on each output handshake.
module tb_uart_packet_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       pkt_ready;
  logic       pkt_valid;
  logic [7:0] pkt_addr;
  logic [7:0] pkt_data;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  uart_packet_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_addr  (pkt_addr),
    .pkt_data  (pkt_data),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } exp_pkt_t;
  exp_pkt_t exp_q[$];

  int   n_par = 0;
  int   n_frm = 0;
  int   n_ovf = 0;
  int   rise_cyc = 0;
  int   last_fall = 0;
  logic pv_prev = 1'b0;

  // Output monitor: pulse counters, rise time, scoreboard compare on handshake.
  always @(negedge clk) begin
    if (rst) begin
      pv_prev = 1'b0;
    end else begin
      if (parity_err) n_par++;
      if (frame_err)  n_frm++;
      if (overflow)   n_ovf++;
      if (pkt_valid && !pv_prev) rise_cyc = cyc;
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          check("pkt_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_pkt_t e;
          e = exp_q.pop_front();
          check("pkt_addr", {24'd0, pkt_addr}, {24'd0, e.a});
          check("pkt_data", {24'd0, pkt_data}, {24'd0, e.d});
        end
      end
      pv_prev = pkt_valid;
    end
  end

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
    last_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ pflip);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] d);
    exp_pkt_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int k = 0;
    while (exp_q.size() != 0 && k < maxc) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {31'd0, pkt_valid}, 32'd0);
    check({tag, "_addr"},  {24'd0, pkt_addr},  32'd0);
    check({tag, "_data"},  {24'd0, pkt_data},  32'd0);
    check({tag, "_perr"},  {31'd0, parity_err}, 32'd0);
    check({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
    check({tag, "_ovf"},   {31'd0, overflow},  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f2, p0, f0, o0;
    rst = 1'b1;
    rxd = 1'b1;
    pkt_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);

    // Basic pair, back-to-back frames, latency from second start edge.
    push_exp(8'h2A, 8'h55);
    rise_cyc = 0;
    send_frame(8'h2A, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    f2 = last_fall;
    idle(5);
    check("t1_latency", 32'(rise_cyc - f2), 32'd170);
    wait_drain("t1_drain", 50);
    check("t1_perr_cnt", 32'(n_par), 32'd0);
    check("t1_ferr_cnt", 32'(n_frm), 32'd0);
    check("t1_ovf_cnt",  32'(n_ovf), 32'd0);

    // Parity error on the address frame.
`ifdef UART_PACKET_RX_PARITY_CHECK_EN
    push_exp(8'h20, 8'h30);
`else
    push_exp(8'h10, 8'h20);
`endif
    send_frame(8'h10, 1'b1, 1'b1);
    send_frame(8'h20, 1'b0, 1'b1);
    send_frame(8'h30, 1'b0, 1'b1);
    idle(20);
    wait_drain("t2_drain", 50);
`ifdef UART_PACKET_RX_PARITY_CHECK_EN
    check("t2_perr_cnt", 32'(n_par), 32'd1);
`else
    check("t2_perr_cnt", 32'(n_par), 32'd0);
`endif

    // Framing error resets pairing.
    f0 = n_frm;
    push_exp(8'h01, 8'h02);
    send_frame(8'hFF, 1'b0, 1'b0);
    idle(20);
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'h02, 1'b0, 1'b1);
    idle(10);
    wait_drain("t3_drain", 50);
    check("t3_ferr_cnt", 32'(n_frm - f0), 32'd1);

    // Overflow with output held, then ready on the completion cycle.
    o0 = n_ovf;
    pkt_ready = 1'b0;
    push_exp(8'hA1, 8'hB1);
    send_frame(8'hA1, 1'b0, 1'b1);
    send_frame(8'hB1, 1'b0, 1'b1);
    send_frame(8'hA2, 1'b0, 1'b1);
    send_frame(8'hB2, 1'b0, 1'b1);
    idle(5);
    check("t4_ovf_cnt",  32'(n_ovf - o0), 32'd1);
    check("t4_hold_vld", {31'd0, pkt_valid}, 32'd1);
    check("t4_hold_addr", {24'd0, pkt_addr}, 32'h0A1);
    check("t4_hold_data", {24'd0, pkt_data}, 32'h0B1);
    push_exp(8'hA3, 8'hB3);
    send_frame(8'hA3, 1'b0, 1'b1);
    fork
      send_frame(8'hB3, 1'b0, 1'b1);
      begin
        repeat (169) @(posedge clk);
        #1;
        pkt_ready = 1'b1;
      end
    join
    idle(5);
    wait_drain("t4_drain", 50);
    check("t4_ovf_cnt2", 32'(n_ovf - o0), 32'd1);

    // Short glitch on an idle line.
    p0 = n_par;
    f0 = n_frm;
    o0 = n_ovf;
    rise_cyc = 0;
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(200);
    check("t5_valid", {31'd0, pkt_valid}, 32'd0);
    check("t5_rise",  32'(rise_cyc), 32'd0);
    check("t5_pulses", 32'((n_par - p0) + (n_frm - f0) + (n_ovf - o0)), 32'd0);

    // Reset in the middle of a data bit.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rxd = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("t6_rst");
    @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    push_exp(8'h77, 8'h88);
    send_frame(8'h77, 1'b0, 1'b1);
    send_frame(8'h88, 1'b0, 1'b1);
    idle(10);
    wait_drain("t6_drain", 50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_packet_rx.md
# uart_packet_rx

- Front-end receive stage of the fifomult datapath.
- Deserialises the UART line into 11-bit frames: start, 8 data bits LSB-first, even parity, stop.
- Pairs consecutive good frames into {address, data} packets.
- Presents each packet on a valid/ready interface to the downstream address-routing FIFO stage.
- Reports parity, framing and overflow errors as single-cycle pulses.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; even, ≥ 4.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  asynchronous UART serial line, idle high.
- pkt_valid  out  1  packet held on pkt_addr/pkt_data.
- pkt_ready  in  1  downstream accepts when high together with pkt_valid.
- pkt_addr  out  8  address byte (first frame of pair).
- pkt_data  out  8  data byte (second frame of pair).
- parity_err  out  1  one-cycle pulse: frame parity mismatch.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overflow  out  1  one-cycle pulse: completed packet dropped, output register occupied.

## Operation
- rxd passes through a 2-flop synchroniser (rxd_s); always present, not configurable.
- Frame FSM states and transitions:
  - IDLE: rxd_s falling (prev 1, now 0) → START, bit counter cleared.
  - START: at count CLKS_PER_BIT/2-1, rxd_s=0 → DATA; rxd_s=1 → false start → IDLE, no error pulse.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples shifted in LSB-first → PARITY.
  - PARITY: one sample → STOP.
  - STOP: one sample. 0 → frame_err, → IDLE. 1 → frame done, → IDLE.
- Parity check: XOR of the 8 data bits and the parity bit must be 0. Mismatch → parity_err and the frame is discarded.
- frame_err takes priority: a frame with both errors pulses frame_err only.
- Pairing flag have_addr:
  - Good frame with have_addr=0: byte latched as address, have_addr←1.
  - Good frame with have_addr=1: packet complete, have_addr←0.
  - Any error pulse: have_addr←0. The next good frame is treated as an address.
- Output register, single entry:
  - Complete packet with pkt_valid=0: load pkt_addr/pkt_data, pkt_valid←1.
  - Complete packet with pkt_valid=1 and no handshake that cycle: drop it, pulse overflow, register unchanged.
  - Complete packet in the same cycle as a pkt_valid&pkt_ready handshake: load the new packet, pkt_valid stays 1, no overflow.
- Once asserted, pkt_valid/pkt_addr/pkt_data hold until the handshake.
- Reset, including mid-frame: FSM→IDLE, counters 0, have_addr=0, shift register 0. Synchroniser flops→1 so reset release on a low line creates no false start.

## Timing
- Reset values: pkt_valid=0, pkt_addr=8'h00, pkt_data=8'h00, parity_err=0, frame_err=0, overflow=0.
- Let t0 = cycle rxd_s is first seen low (2 cycles after rxd falls).
- Start mid-sample at t0+CLKS_PER_BIT/2-1.
- Sample for bit k (1..8 data, 9 parity, 10 stop) at t0+CLKS_PER_BIT/2-1+k·CLKS_PER_BIT. For 16: stop at t0+167.
- Error/overflow pulses and pkt_valid rise on the cycle after the stop sample (t0+168 for 16).
- FSM returns to IDLE right after the stop sample. It accepts a new start edge from the next cycle, so back-to-back frames with a single stop bit work.
- Pulses are exactly one cycle wide.

## Configuration
- Macro UART_PACKET_RX_PARITY_CHECK_EN.
- Defined: parity is checked as above.
- Undefined: the parity bit is still sampled (frame length unchanged) but ignored. parity_err is tied 0, and only frame_err resets pairing.

## Structure
- fifomult_pkg holds:
  - CLKS_PER_BIT default
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - rx_packet_t struct {addr_t addr; data byte}
- Sub-module uart_rx_frame:
  - contains the synchroniser, FSM, counters and parity check
  - outputs byte[7:0], byte_valid pulse, parity_err, frame_err
- Top uart_packet_rx: pairing logic and output register.

## Test plan
- Reset, then frames 8'h2A (parity 1) and 8'h55 (parity 0), pkt_ready=1 → pkt_valid at t0+168 of the second frame; pkt_addr=2A, pkt_data=55; no error pulses.
- Address 8'h10 with parity bit flipped, then 8'h20, 8'h30 → parity_err once; single packet {20,30}. With the macro undefined → packet {10,20}, no parity_err.
- Frame 8'hFF with stop=0 → frame_err pulse; the next two good frames 01,02 form packet {01,02}.
- pkt_ready=0, send packets {A1,B1} then {A2,B2} → overflow pulse at second completion; register still {A1,B1}. Raise pkt_ready on the exact completion cycle of {A3,B3} → no overflow, register loads {A3,B3}.
- 3-cycle low glitch on idle rxd → no state leaves IDLE after start check, no outputs.
- Assert rst mid-DATA of an address frame, release, send 8'h77, 8'h88 → packet {77,88}; all outputs 0 during reset.
